// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   requests instructions over a req/ready handshake and presents one
//   registered output slot (instruction, its address, address+4, valid).
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        synchronous active-low reset
//   stall        IF/ID does not capture this cycle; slot is held
//   redirect     taken branch / flush, load redirect_pc
//   redirect_pc  new fetch address, bits [1:0] forced to zero
//   imem_req     request outstanding to instruction memory
//   imem_addr    registered request address, stable while imem_req=1
//   imem_ready   memory response for the outstanding request
//   imem_rdata   instruction word, valid when imem_req & imem_ready
//   Inst_IF      fetched instruction (NOP_INST when fetch_valid=0)
//   PC_out_IF    address of Inst_IF
//   Add_4_IF     PC_out_IF + 4, wrapping
//   fetch_valid  slot holds a real instruction
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, no request
// REQ   | request pending or outstanding at the current pc
// DROP  | stale request outstanding after a redirect; its data is thrown away
module if_fetch_stage #(
  parameter int                PC_W     = 64,
  parameter int                INST_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = 32'hD503201F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] Inst_IF,
  output logic [PC_W-1:0]   PC_out_IF,
  output logic [PC_W-1:0]   Add_4_IF,
  output logic              fetch_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [PC_W-1:0] PC_INC     = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_addr;
  logic              r_held;
  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [PC_W-1:0]   r_pc_out;
  logic [PC_W-1:0]   r_add4;

  logic              w_slot_free;
  logic              w_req;
  logic              w_hit;
  logic [PC_W-1:0]   w_addr_inc;
  logic [PC_W-1:0]   w_redir_pc;

  // A new request is only raised when the slot is empty or being consumed
  // this cycle, so a response can never overwrite an unconsumed slot. Once
  // raised and not answered, r_held keeps it up regardless of stall. Raising
  // combinationally lets a stall release consume and issue in the same cycle.
  assign w_slot_free = !r_valid || !stall;
  assign w_req       = (r_state == S_DROP) ||
                       ((r_state == S_REQ) && (r_held || w_slot_free));
  assign w_hit       = w_req && imem_ready;
  assign w_addr_inc  = r_addr + PC_INC;
  assign w_redir_pc  = redirect_pc & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_addr   <= RESET_PC;
      r_held   <= 1'b0;
      r_valid  <= 1'b0;
      r_inst   <= NOP_INST;
      r_pc_out <= RESET_PC;
      r_add4   <= RESET_PC + PC_INC;
    end else if (redirect) begin
      r_pc    <= w_redir_pc;
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_held  <= 1'b0;
      // Unanswered request still visible to memory: keep presenting it at
      // the stale address until it completes.
      if (w_req && !imem_ready) begin
        r_state <= S_DROP;
      end else begin
        r_state <= S_REQ;
        r_addr  <= w_redir_pc;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (!stall) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
          end
          if (w_hit) begin
            r_inst   <= imem_rdata;
            r_pc_out <= r_addr;
            r_add4   <= w_addr_inc;
            r_valid  <= 1'b1;
            r_pc     <= w_addr_inc;
            r_addr   <= w_addr_inc;
            r_held   <= 1'b0;
          end else if (w_req) begin
            r_held <= 1'b1;
          end
        end
        S_DROP: begin
          if (imem_ready) begin
            r_state <= S_REQ;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_addr;
  assign Inst_IF     = r_inst;
  assign PC_out_IF   = r_pc_out;
  assign Add_4_IF    = r_add4;
  assign fetch_valid = r_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_ready = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] Inst_IF;
  logic [63:0] PC_out_IF;
  logic [63:0] Add_4_IF;
  logic        fetch_valid;

  // second instance exercising PC wrap-around, free-running zero-wait memory
  logic        w_ready = 1'b1;
  logic        w_req;
  logic [63:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_inst;
  logic [63:0] w_pc_out;
  logic [63:0] w_add4;
  logic        w_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] add4;
    logic [31:0] inst;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  // memory returns the address as the instruction word
  assign imem_rdata = imem_addr[31:0];
  assign w_rdata    = w_addr[31:0];

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Inst_IF(Inst_IF),
    .PC_out_IF(PC_out_IF), .Add_4_IF(Add_4_IF), .fetch_valid(fetch_valid)
  );

  if_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(64'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata), .Inst_IF(w_inst),
    .PC_out_IF(w_pc_out), .Add_4_IF(w_add4), .fetch_valid(w_valid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [63:0] add4, input logic [31:0] inst);
    exp_t e;
    e.pc = pc; e.add4 = add4; e.inst = inst;
    q.push_back(e);
  endtask

  // Monitor: a slot is new when the previous cycle had no valid slot or the
  // previous slot was consumed (stall low at the edge).
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (reset && fetch_valid && (!prev_valid || !prev_stall)) begin
      if (q.size() == 0) begin
        chk("unexpected_fetch_pc", PC_out_IF, 64'hXXXX_XXXX_XXXX_XXXX);
      end else begin
        chk("sb_pc",   PC_out_IF, q[0].pc);
        chk("sb_add4", Add_4_IF,  q[0].add4);
        chk("sb_inst", {32'h0, Inst_IF}, {32'h0, q[0].inst});
        void'(q.pop_front());
      end
    end
    prev_valid <= reset ? fetch_valid : 1'b0;
    prev_stall <= stall;
  end

  initial begin
    // reset held with memory ready
    repeat (3) step();
    chk("rst_req",   {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, fetch_valid}, 64'h0);
    chk("rst_inst",  {32'h0, Inst_IF}, {32'h0, NOP});
    chk("rst_pc",    PC_out_IF, 64'h0);
    chk("rst_add4",  Add_4_IF, 64'h4);
    chk("rst_addr",  imem_addr, 64'h0);
    chk("rst_wrap_pc",   w_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("rst_wrap_add4", w_add4, 64'h0);

    // release with memory not ready: request at 0 waits 3 cycles
    reset = 1'b1;
    imem_ready = 1'b0;
    step();
    chk("wait1_req", {63'h0, imem_req}, 64'h1);
    chk("wait1_addr", imem_addr, 64'h0);
    step();
    chk("wait2_addr", imem_addr, 64'h0);
    chk("wrap_pc",   w_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_add4", w_add4, 64'h0);
    chk("wrap_inst", {32'h0, w_inst}, 64'hFFFF_FFFC);
    step();
    chk("wait3_addr", imem_addr, 64'h0);
    chk("wait3_valid", {63'h0, fetch_valid}, 64'h0);
    chk("wrap_next_pc",   w_pc_out, 64'h0);
    chk("wrap_next_add4", w_add4, 64'h4);

    // zero-wait streaming 0,4,8,C
    push(64'h0, 64'h4, 32'h0);
    push(64'h4, 64'h8, 32'h4);
    push(64'h8, 64'hC, 32'h8);
    push(64'hC, 64'h10, 32'hC);
    imem_ready = 1'b1;
    step();
    chk("first_pc", PC_out_IF, 64'h0);
    chk("first_add4", Add_4_IF, 64'h4);
    step();
    step();
    chk("pre_stall_pc", PC_out_IF, 64'h8);

    // stall with full slot for 4 edges
    stall = 1'b1;
    #1;
    chk("stall_req_now", {63'h0, imem_req}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_pc", PC_out_IF, 64'h8);
      chk("stall_valid", {63'h0, fetch_valid}, 64'h1);
      chk("stall_req", {63'h0, imem_req}, 64'h0);
    end
    stall = 1'b0;
    #1;
    chk("release_req", {63'h0, imem_req}, 64'h1);
    chk("release_addr", imem_addr, 64'hC);
    step();
    chk("release_pc", PC_out_IF, 64'hC);

    // outstanding request at 0x10, redirect to 0x403 while waiting
    imem_ready = 1'b0;
    #1;
    chk("out_addr", imem_addr, 64'h10);
    step();
    redirect = 1'b1;
    redirect_pc = 64'h403;
    step();
    redirect = 1'b0;
    chk("drop_valid", {63'h0, fetch_valid}, 64'h0);
    chk("drop_inst", {32'h0, Inst_IF}, {32'h0, NOP});
    chk("drop_req", {63'h0, imem_req}, 64'h1);
    chk("drop_addr", imem_addr, 64'h10);
    step();
    chk("drop_addr_hold", imem_addr, 64'h10);
    push(64'h400, 64'h404, 32'h400);
    imem_ready = 1'b1;
    step();
    chk("target_addr", imem_addr, 64'h400);
    chk("target_req", {63'h0, imem_req}, 64'h1);
    step();
    chk("target_pc", PC_out_IF, 64'h400);
    chk("target_add4", Add_4_IF, 64'h404);

    // redirect with response in the same cycle: no DROP cycle
    redirect = 1'b1;
    redirect_pc = 64'h803;
    push(64'h800, 64'h804, 32'h800);
    step();
    redirect = 1'b0;
    chk("nodrop_addr", imem_addr, 64'h800);
    chk("nodrop_valid", {63'h0, fetch_valid}, 64'h0);
    chk("nodrop_inst", {32'h0, Inst_IF}, {32'h0, NOP});
    step();
    imem_ready = 1'b0;
    repeat (2) step();
    chk("queue_empty", 64'(q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
